// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding and default operand width for the arithmetic lab cells.
// Contents: state_t (ST_IDLE, ST_SHIFT, ST_DONE), DEFAULT_WIDTH.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit combinational full subtractor, a - b - borrow.
// Ports: a_in, b_in, borrow_in -> diff_out, borrow_out.
module full_subtractor (
    input  logic a_in,
    input  logic b_in,
    input  logic borrow_in,
    output logic diff_out,
    output logic borrow_out
);

    assign diff_out   = a_in ^ b_in ^ borrow_in;
    assign borrow_out = (~a_in & b_in) | (~(a_in ^ b_in) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, with a start/done handshake.
// Ports: clk_in, rst_n_in (sync, active-low), start_in, a_in, b_in ->
//        ready_out, busy_out, done_out, diff_out ((a-b) mod 2^WIDTH), borrow_out (a < b).
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d;
    logic             br_next;
    logic             last;

    full_subtractor u_fs (
        .a_in      (a_sr[0]),
        .b_in      (b_sr[0]),
        .borrow_in (br),
        .diff_out  (d),
        .borrow_out(br_next)
    );

    assign last = cnt == CW'(WIDTH - 1);

    // Handshake flags decode the state register only, so they stay registered and one-hot.
    assign ready_out = state == ST_IDLE;
    assign busy_out  = state == ST_SHIFT;
    assign done_out  = state == ST_DONE;

    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE:  state_next = start_in ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_next = last ? ST_DONE : ST_SHIFT;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state      <= ST_IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res        <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            diff_out   <= '0;
            borrow_out <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && start_in) begin
                a_sr       <= a_in;
                b_sr       <= b_in;
                cnt        <= '0;
                br         <= 1'b0;
                diff_out   <= '0;
                borrow_out <= 1'b0;
            end else if (state == ST_SHIFT) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                res  <= {d, res[WIDTH-1:1]};
                br   <= br_next;
                cnt  <= cnt + 1'b1;
                // Publish on the final shift edge so the result is already visible in DONE.
                if (last) begin
                    diff_out   <= {d, res[WIDTH-1:1]};
                    borrow_out <= br_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor (WIDTH 8 and 4).
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       ready4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       borrow4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .start_in  (start),
        .a_in      (a),
        .b_in      (b),
        .ready_out (ready),
        .busy_out  (busy),
        .done_out  (done),
        .diff_out  (diff),
        .borrow_out(borrow)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .start_in  (start4),
        .a_in      (a4),
        .b_in      (b4),
        .ready_out (ready4),
        .busy_out  (busy4),
        .done_out  (done4),
        .diff_out  (diff4),
        .borrow_out(borrow4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and return the cycle (after acceptance) in which done rose, or -1.
    task automatic run8(input logic [7:0] ai, input logic [7:0] bi, output int lat);
        a = ai;
        b = bi;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            tick();
        end
    endtask

    task automatic run4(input logic [3:0] ai, input logic [3:0] bi, output int lat);
        a4 = ai;
        b4 = bi;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (done4) begin
                lat = c;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks += 5;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff got %h want 00", diff); end
        if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b want 0", borrow); end
        rst_n = 1'b1;
        tick();
        a = 8'hF0;
        b = 8'h0F;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy got %b want 1", busy); end
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({ready, busy, done, diff, borrow} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0})
            begin errors++; $display("FAIL reset_in_shift got r%b b%b d%b %h %b want r1 b0 d0 00 0", ready, busy, done, diff, borrow); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        int lat;
        run8(8'h5A, 8'h3C, lat);
        checks += 4;
        if (lat !== 9) begin errors++; $display("FAIL basic_latency got %0d want 9", lat); end
        if (diff !== 8'h1E) begin errors++; $display("FAIL basic_diff got %h want 1e", diff); end
        if (borrow !== 1'b0) begin errors++; $display("FAIL basic_borrow got %b want 0", borrow); end
        if ({ready, busy} !== 2'b00) begin errors++; $display("FAIL basic_onehot got r%b b%b want r0 b0", ready, busy); end
        tick();
        checks++;
        if ({ready, busy, done} !== 3'b100) begin errors++; $display("FAIL basic_pulse got r%b b%b d%b want r1 b0 d0", ready, busy, done); end
    endtask

    task automatic test_borrow;
        logic [7:0] va [3] = '{8'h03, 8'h00, 8'hFF};
        logic [7:0] vb [3] = '{8'h05, 8'h01, 8'hFF};
        logic [7:0] vd [3] = '{8'hFE, 8'hFF, 8'h00};
        logic       vbr[3] = '{1'b1, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run8(va[i], vb[i], lat);
            checks += 3;
            if (lat !== 9) begin errors++; $display("FAIL borrow_latency[%0d] got %0d want 9", i, lat); end
            if (diff !== vd[i]) begin errors++; $display("FAIL borrow_diff[%0d] got %h want %h", i, diff, vd[i]); end
            if (borrow !== vbr[i]) begin errors++; $display("FAIL borrow_flag[%0d] got %b want %b", i, borrow, vbr[i]); end
            tick();
        end
    endtask

    task automatic test_handshake;
        int first;
        int gap;
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        tick();
        a = 8'h77;
        b = 8'h22;
        first = -1;
        for (int c = 1; c <= 30; c++) begin
            if (done) begin
                first = c;
                break;
            end
            tick();
        end
        checks += 3;
        if (first !== 9) begin errors++; $display("FAIL hs_first_latency got %0d want 9", first); end
        if (diff !== 8'h0F) begin errors++; $display("FAIL hs_first_diff got %h want 0f", diff); end
        if (borrow !== 1'b0) begin errors++; $display("FAIL hs_first_borrow got %b want 0", borrow); end
        gap = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (done) begin
                gap = c;
                break;
            end
        end
        start = 1'b0;
        checks += 2;
        if (gap !== 10) begin errors++; $display("FAIL hs_period got %0d want 10", gap); end
        if (diff !== 8'h55) begin errors++; $display("FAIL hs_second_diff got %h want 55", diff); end
        tick();
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL hs_release_ready got %b want 1", ready); end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic seen;
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            seen |= done;
            tick();
        end
        checks += 2;
        if (seen !== 1'b0) begin errors++; $display("FAIL mid_abort_done got %b want 0", seen); end
        if (diff !== 8'h00) begin errors++; $display("FAIL mid_abort_diff got %h want 00", diff); end
        run8(8'h80, 8'h01, lat);
        checks += 3;
        if (lat !== 9) begin errors++; $display("FAIL mid_latency got %0d want 9", lat); end
        if (diff !== 8'h7F) begin errors++; $display("FAIL mid_diff got %h want 7f", diff); end
        if (borrow !== 1'b0) begin errors++; $display("FAIL mid_borrow got %b want 0", borrow); end
        tick();
        tick();
        tick();
        checks++;
        if ({diff, borrow} !== {8'h7F, 1'b0}) begin errors++; $display("FAIL mid_hold got %h %b want 7f 0", diff, borrow); end
    endtask

    task automatic test_exhaustive4;
        int lat;
        logic [3:0] want_d;
        logic want_b;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run4(4'(i), 4'(j), lat);
                want_d = 4'((i - j + 16) % 16);
                want_b = i < j;
                checks++;
                if (lat !== 5 || diff4 !== want_d || borrow4 !== want_b)
                    begin errors++; $display("FAIL exh4 a=%0d b=%0d got lat %0d %h %b want lat 5 %h %b", i, j, lat, diff4, borrow4, want_d, want_b); end
                tick();
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        start4 = 1'b0;
        a4 = '0;
        b4 = '0;
        test_reset();
        test_basic();
        test_borrow();
        test_handshake();
        test_reset_mid();
        test_exhaustive4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
